// File: rtl/sensor_request_ctrl.sv
// Sensor request controller: sends a sensor id over UART, collects and checks the
// response frame, retries on timeout/checksum failure and reports status in result.
module sensor_request_ctrl #(
  parameter int unsigned NUM_SENSORS    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned DATA_BYTES     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clock_en,
  input  logic        start,
  input  logic [31:0] dataA,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  localparam int unsigned FrameLen = DATA_BYTES + 2;
  localparam int unsigned TimerW   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle, StSend, StWait, StCheck, StDone, StAlarm, StFlush
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              id_q, id_d;
  logic [2:0]              retries_q, retries_d;
  logic [2:0]              idx_q, idx_d;
  logic [TimerW-1:0]       timer_q, timer_d;
  logic [8*FrameLen-1:0]   frame_q, frame_d;
  logic [3:0]              flush_q, flush_d;
  logic [31:0]             result_q, result_d;

  logic [23:0] payload;
  logic [7:0]  csum;
  logic        fail;

  // Payload bytes arrive MSB first; checksum covers echoed id and payload.
  always_comb begin
    payload = '0;
    csum    = '0;
    for (int unsigned i = 1; i <= DATA_BYTES; i++) begin
      payload = {payload[15:0], frame_q[8*i +: 8]};
    end
    for (int unsigned i = 0; i <= DATA_BYTES; i++) begin
      csum = csum ^ frame_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    retries_d = retries_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    frame_d   = frame_q;
    flush_d   = flush_q;
    result_d  = result_q;
    fail      = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (32'(dataA[7:0]) < NUM_SENSORS) begin
            id_d      = dataA[7:0];
            retries_d = '0;
            result_d  = '0;
            state_d   = StSend;
          end else begin
            result_d = 32'h8000_0000;
            state_d  = StDone;
          end
        end
      end
      StSend: begin
        if (tx_ready) begin
          idx_d   = '0;
          timer_d = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (rx_valid) begin
          for (int unsigned i = 0; i < FrameLen; i++) begin
            if (idx_q == 3'(i)) frame_d[8*i +: 8] = rx_data;
          end
          timer_d = '0;
          if (idx_q == 3'(FrameLen - 1)) state_d = StCheck;
          else idx_d = idx_q + 3'd1;
        end else if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
          fail = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StCheck: begin
        if (frame_q[7:0] == id_q && frame_q[8*(FrameLen-1) +: 8] == csum) begin
          result_d = {2'b00, retries_q, 3'b000, payload};
          state_d  = StDone;
        end else begin
          fail = 1'b1;
        end
      end
      StFlush: begin
        frame_d = '0;
        if (flush_q == 4'd15) state_d = StSend;
        else flush_d = flush_q + 4'd1;
      end
      StAlarm: begin
        result_d = {2'b01, retries_q, 3'b000, 24'h000000};
        state_d  = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (fail) begin
      if (retries_q < 3'(MAX_RETRIES)) begin
        retries_d = retries_q + 3'd1;
        flush_d   = '0;
        state_d   = StFlush;
      end else begin
        state_d = StAlarm;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      id_q      <= '0;
      retries_q <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
      frame_q   <= '0;
      flush_q   <= '0;
      result_q  <= '0;
    end else if (clock_en) begin
      state_q   <= state_d;
      id_q      <= id_d;
      retries_q <= retries_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      frame_q   <= frame_d;
      flush_q   <= flush_d;
      result_q  <= result_d;
    end
  end

  assign result   = result_q;
  assign done     = (state_q == StDone);
  assign busy     = (state_q != StIdle);
  assign tx_valid = (state_q == StSend);
  assign tx_data  = tx_valid ? id_q : 8'h00;

endmodule

// File: tb/tb_sensor_request_ctrl.sv
// Directed self-checking bench for sensor_request_ctrl with hand-computed results.
module tb_sensor_request_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clock_en = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dataA = '0;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int tx_cnt = 0;
  logic [7:0] last_tx = '0;

  sensor_request_ctrl #(
    .NUM_SENSORS   (8),
    .TIMEOUT_CYCLES(20),
    .MAX_RETRIES   (3),
    .DATA_BYTES    (2)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .clock_en(clock_en),
    .start   (start),
    .dataA   (dataA),
    .result  (result),
    .done    (done),
    .busy    (busy),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (!reset && clock_en && tx_valid && tx_ready) begin
      tx_cnt  <= tx_cnt + 1;
      last_tx <= tx_data;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
  endtask

  task automatic issue(input logic [31:0] a);
    start = 1'b1;
    dataA = a;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t0;
    logic ok;

    // Reset state
    step();
    step();
    chk("rst_result", result, 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    reset = 1'b0;
    step();

    // Nominal: id 3, reply 03 12 34 25; upper dataA bits ignored
    t0 = tx_cnt;
    issue(32'h0000_FF03);
    chk("nom_tx_valid", 32'(tx_valid), 32'h1);
    chk("nom_tx_data", 32'(tx_data), 32'h03);
    step();
    issue(32'h0000_000A);  // ignored while busy
    send_frame(8'h03, 8'h12, 8'h34, 8'h25);
    chk("nom_check_done", 32'(done), 32'h0);
    chk("nom_check_busy", 32'(busy), 32'h1);
    step();
    chk("nom_done", 32'(done), 32'h1);
    chk("nom_result", result, 32'h0000_1234);
    step();
    chk("nom_done_pulse", 32'(done), 32'h0);
    chk("nom_idle_busy", 32'(busy), 32'h0);
    chk("nom_result_hold", result, 32'h0000_1234);
    chk("nom_tx_count", 32'(tx_cnt - t0), 32'd1);
    chk("nom_tx_byte", 32'(last_tx), 32'h03);

    // Bad id
    t0 = tx_cnt;
    issue(32'h0000_000A);
    chk("bad_done", 32'(done), 32'h1);
    chk("bad_result", result, 32'h8000_0000);
    chk("bad_tx_valid", 32'(tx_valid), 32'h0);
    step();
    chk("bad_tx_count", 32'(tx_cnt - t0), 32'd0);

    // Checksum error then recovery
    t0 = tx_cnt;
    issue(32'h0000_0003);
    step();
    send_frame(8'h03, 8'h12, 8'h34, 8'h00);
    step();
    send_byte(8'hFF);  // discarded during flush
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (tx_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("cks_resend_seen", 32'(ok), 32'h1);
    step();
    send_frame(8'h03, 8'h12, 8'h34, 8'h25);
    wait_done(10, ok);
    chk("cks_done_seen", 32'(ok), 32'h1);
    chk("cks_result", result, 32'h0800_1234);
    chk("cks_tx_count", 32'(tx_cnt - t0), 32'd2);
    step();

    // Silent sensor: four transmissions then alarm
    t0 = tx_cnt;
    issue(32'h0000_0005);
    wait_done(400, ok);
    chk("sil_done_seen", 32'(ok), 32'h1);
    chk("sil_result", result, 32'h5800_0000);
    chk("sil_tx_count", 32'(tx_cnt - t0), 32'd4);
    step();

    // clock_en low during WAIT freezes the timer
    issue(32'h0000_0002);
    step();
    for (int i = 0; i < 15; i++) step();
    clock_en = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("frz_busy", 32'(busy), 32'h1);
    chk("frz_done", 32'(done), 32'h0);
    clock_en = 1'b1;
    send_frame(8'h02, 8'hAB, 8'hCD, 8'h64);
    wait_done(10, ok);
    chk("frz_done_seen", 32'(ok), 32'h1);
    chk("frz_result", result, 32'h0000_ABCD);
    step();

    // Reset mid-WAIT, with clock_en low to show reset priority
    issue(32'h0000_0001);
    step();
    step();
    step();
    chk("rmw_busy_before", 32'(busy), 32'h1);
    clock_en = 1'b0;
    reset    = 1'b1;
    step();
    chk("rmw_result", result, 32'h0);
    chk("rmw_done", 32'(done), 32'h0);
    chk("rmw_busy", 32'(busy), 32'h0);
    chk("rmw_tx_valid", 32'(tx_valid), 32'h0);
    chk("rmw_tx_data", 32'(tx_data), 32'h0);
    reset    = 1'b0;
    clock_en = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sensor_request_ctrl.md
SENSOR_REQUEST_CTRL -- requirements
Module: sensor_request_ctrl

Interface
REQ-001 Parameters: NUM_SENSORS, 8, number of addressable sensors (1..256); TIMEOUT_CYCLES, 50000, enabled cycles allowed per expected response byte; MAX_RETRIES, 3, retransmissions before alarm (0..7); DATA_BYTES, 2, sensor payload bytes (1..3).
REQ-002 clock  in  1  system clock; all logic on rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 clock_en  in  1  advance enable; when low, all registers hold, except on reset.
REQ-005 start  in  1  request strobe, sampled only in IDLE.
REQ-006 dataA  in  32  request operand; dataA[7:0] = sensor id; dataA[31:8] ignored.
REQ-007 result  out  32  [31:30] status (00 ok, 01 timeout alarm, 10 bad id, 11 unused), [29:27] retries used, [26:24] zero, [23:0] payload zero-extended.
REQ-008 done  out  1  one-enabled-cycle pulse; result is valid from this cycle.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 tx_data  out  8  byte to the UART transmitter.
REQ-011 tx_valid  out  1  tx_data valid; held until tx_ready.
REQ-012 tx_ready  in  1  transmitter accepts the byte when tx_valid and tx_ready are both high.
REQ-013 rx_data  in  8  byte from the UART receiver.
REQ-014 rx_valid  in  1  single-cycle strobe, one per received byte.

Function
REQ-015 States: IDLE, SEND, WAIT, CHECK, DONE, ALARM, FLUSH; transitions occur only on cycles with clock_en high.
REQ-016 IDLE with start=1 and dataA[7:0] < NUM_SENSORS: latch the id, clear the retry count, go to SEND.
REQ-017 IDLE with start=1 and dataA[7:0] >= NUM_SENSORS: go to DONE with status 10 and payload 0; tx_valid never asserts.
REQ-018 start outside IDLE is ignored and has no effect on the transaction in progress.
REQ-019 SEND: tx_valid=1 and tx_data=latched id; on handshake, go to WAIT with the byte index and timer cleared.
REQ-020 Response frame is, in order: echoed id, DATA_BYTES payload bytes (MSB first), checksum = XOR of all preceding frame bytes.
REQ-021 WAIT: each rx_valid stores the byte at the current index and clears the timer; after the last byte (index DATA_BYTES+1), go to CHECK.
REQ-022 WAIT: the timer increments on each enabled cycle without rx_valid; reaching TIMEOUT_CYCLES is a failure event.
REQ-023 CHECK, one cycle: the frame passes only if the echoed id matches and the checksum matches; pass goes to DONE with status 00; mismatch is a failure event.
REQ-024 On a failure event: if retries < MAX_RETRIES, increment retries and go to FLUSH; otherwise go to ALARM.
REQ-025 FLUSH lasts exactly 16 enabled cycles, discards all rx_valid bytes, clears the frame buffer, then goes to SEND.
REQ-026 ALARM, one cycle: load status 01 and payload 0, then go to DONE.
REQ-027 DONE: done=1 for one enabled cycle, then go to IDLE; result holds until the next accepted start.
REQ-028 rx_valid in IDLE, SEND, CHECK, DONE or ALARM is discarded.
REQ-029 Minimum latency: start → SEND is 1 cycle; last response byte → done is 2 cycles (CHECK, DONE).

Reset
REQ-030 Reset has priority over clock_en, including mid-transaction.
REQ-031 On reset: state=IDLE, result=0, done=0, busy=0, tx_valid=0, tx_data=0; timer, index, retry count and frame buffer are cleared.

Verification
REQ-032 Nominal: id 3, tx_ready=1, reply 03,12,34,25 → one tx byte 03; done with result=0x00001234.
REQ-033 Bad id: NUM_SENSORS=8, dataA=0x0000000A → done 1 cycle later, result=0x80000000, tx_valid stays 0.
REQ-034 Checksum error then recovery: first reply 03,12,34,00, second reply correct → two tx bytes, result=0x08001234 (retries=1).
REQ-035 Silent sensor: TIMEOUT_CYCLES=20, MAX_RETRIES=3, no rx → four tx bytes; done with result=0x58000000.
REQ-036 clock_en low for 10 cycles during WAIT with no rx → timer frozen, no timeout; reset asserted mid-WAIT → all outputs at reset values on the next cycle.
